// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state, counter width and error-cause constants for the data-memory responder
package dmem_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int WAIT_CNT_W = 4;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] MISALIGN = 2'd1;
  localparam logic [1:0] RANGE = 2'd2;
  localparam logic [1:0] BOTH = 2'd3;
endpackage

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: wait-state FSM, countdown and request capture for one outstanding access
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_idx,
  input  logic [31:0]           req_din,
  output logic                  idle,
  output logic                  mem_stall,
  output logic                  done,
  output logic                  cap_wen,
  output logic [ADDR_WIDTH-1:0] cap_idx,
  output logic [31:0]           cap_din
);
  localparam logic HAS_WAIT = WAIT_STATES > 0;
  localparam logic [WAIT_CNT_W-1:0] LOAD = WAIT_CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state, state_d;
  logic [WAIT_CNT_W-1:0] cnt, cnt_d;
  logic load, counting;
  // next state, countdown and stall; the accept cycle already stalls
  always_comb begin
    idle = state == IDLE;
    load = idle & accept & HAS_WAIT;
    counting = !idle & (cnt != '0);
    done = !idle & (cnt == '0);
    mem_stall = load | counting;
    state_d = load ? WAIT : done ? IDLE : state;
    cnt_d = load ? LOAD : counting ? cnt - 1'b1 : cnt;
  end
  // state register and capture of the accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cap_wen <= 1'b0;
      cap_idx <= '0;
      cap_din <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (load) begin
        cap_wen <= req_wen;
        cap_idx <= req_idx;
        cap_din <= req_din;
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM with configurable wait states, request checking and a debug peek port
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_din,
  output logic [31:0]           mem_dout,
  output logic                  mem_stall,
  output logic                  mem_err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);
  logic [31:0] ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx, cap_idx, widx;
  logic [31:0] cap_din, wdata;
  logic req, valid, accept, direct, idle, stall, done, cap_wen, we;
  dmem_wait_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_STATES(WAIT_STATES)) u_ctrl (
    .clk(clk), .rst(rst), .accept(accept), .req_wen(mem_wen), .req_idx(idx), .req_din(mem_din),
    .idle(idle), .mem_stall(stall), .done(done), .cap_wen(cap_wen), .cap_idx(cap_idx), .cap_din(cap_din)
  );
  // decode, error pulse, write port selection and read data; zero-wait builds complete in the accept cycle
  always_comb begin
    idx = mem_addr[ADDR_WIDTH+1:2];
    req = idle & (mem_ren | mem_wen) & !rst;
    valid = (mem_ren ^ mem_wen) & (mem_addr[1:0] == 2'b00) & (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    accept = req & valid;
    direct = accept & (WAIT_STATES == 0);
    mem_err = req & !valid;
    mem_stall = stall & !rst;
    we = !rst & ((done & cap_wen) | (direct & mem_wen));
    widx = done ? cap_idx : idx;
    wdata = done ? cap_din : mem_din;
    mem_dout = (!rst & done & !cap_wen) ? ram[cap_idx] : (direct & mem_ren) ? ram[idx] : '0;
    dbg_data = ram[dbg_addr];
  end
  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) ram[widx] <= wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a two-wait-state and a zero-wait-state responder
module tb_dmem_responder;
  logic clk = 0, rst = 1, ren = 0, wen = 0;
  logic [31:0] addr = 0, din = 0;
  logic [9:0] dbg_addr = 0;
  logic [31:0] dout, dbg, dout0, dbg0;
  logic stall, err, stall0, err0;
  int checks = 0, failures = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr), .mem_din(din),
    .mem_dout(dout), .mem_stall(stall), .mem_err(err), .dbg_addr(dbg_addr), .dbg_data(dbg)
  );
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr), .mem_din(din),
    .mem_dout(dout0), .mem_stall(stall0), .mem_err(err0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ren = r; wen = w; addr = a; din = d;
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 1, a, d);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst = 1;
    cyc(1, 0, 32'h12, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", dout); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rst_err0 got=%b exp=0", err0); end
    cyc(0, 0, 0, 0);
    rst = 0;
    cyc(0, 0, 0, 0);
    checks++; if ({stall, err, dout} !== 34'h0) begin failures++; $display("FAIL idle_after_rst got=%b%b/%h exp=00/0", stall, err, dout); end
  endtask

  task automatic test_write;
    cyc(0, 1, 32'h10, 32'hDEADBEEF);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL wr_stall_c0 got=%b exp=1", stall); end
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL wr_stall_c1 got=%b exp=1", stall); end
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wr_stall_c2 got=%b exp=0", stall); end
    cyc(0, 0, 0, 0);
    dbg_addr = 4; #1;
    checks++; if (dbg !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_dbg got=%h exp=deadbeef", dbg); end
  endtask

  task automatic test_read;
    cyc(1, 0, 32'h10, 0);
    checks++; if ({stall, dout} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rd_c0 got=%b/%h exp=1/0", stall, dout); end
    cyc(0, 0, 0, 0);
    checks++; if ({stall, dout} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rd_c1 got=%b/%h exp=1/0", stall, dout); end
    cyc(0, 0, 0, 0);
    checks++; if ({stall, dout} !== {1'b0, 32'hDEADBEEF}) begin failures++; $display("FAIL rd_c2 got=%b/%h exp=0/deadbeef", stall, dout); end
    cyc(0, 0, 0, 0);
    checks++; if ({stall, dout} !== {1'b0, 32'h0}) begin failures++; $display("FAIL rd_c3 got=%b/%h exp=0/0", stall, dout); end
  endtask

  task automatic test_errors;
    logic [31:0] av [3];
    logic [1:0] rw [3];
    av = '{32'h12, 32'h1000, 32'h10};
    rw = '{2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      cyc(rw[i][1], rw[i][0], av[i], 32'h0BAD0BAD);
      checks++; if ({err, stall, dout} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("FAIL err_%0d got=%b%b/%h exp=10/0", i, err, stall, dout); end
      checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL err0_%0d got=%b exp=1", i, err0); end
      cyc(0, 0, 0, 0);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse_%0d got=%b exp=0", i, err); end
    end
    dbg_addr = 4; #1;
    checks++; if (dbg !== 32'hDEADBEEF) begin failures++; $display("FAIL err_nowrite got=%h exp=deadbeef", dbg); end
  endtask

  task automatic test_capture;
    wr(32'h0, 32'h11111111);
    cyc(0, 1, 32'hFFC, 32'h12345678);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cap_stall_c0 got=%b exp=1", stall); end
    cyc(0, 1, 32'h0, 32'h0);
    checks++; if ({stall, err} !== 2'b10) begin failures++; $display("FAIL cap_c1 got=%b%b exp=10", stall, err); end
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL cap_stall_c2 got=%b exp=0", stall); end
    cyc(0, 0, 0, 0);
    dbg_addr = 10'd1023; #1;
    checks++; if (dbg !== 32'h12345678) begin failures++; $display("FAIL cap_top got=%h exp=12345678", dbg); end
    dbg_addr = 10'd0; #1;
    checks++; if (dbg !== 32'h11111111) begin failures++; $display("FAIL cap_word0 got=%h exp=11111111", dbg); end
  endtask

  task automatic test_reset_wait;
    wr(32'h20, 32'h88888888);
    cyc(0, 1, 32'h20, 32'hCAFEF00D);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rw_stall_c0 got=%b exp=1", stall); end
    rst = 1;
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rw_stall_rst got=%b exp=0", stall); end
    rst = 0;
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rw_stall_after got=%b exp=0", stall); end
    dbg_addr = 10'd8; #1;
    checks++; if (dbg !== 32'h88888888) begin failures++; $display("FAIL rw_dropped got=%h exp=88888888", dbg); end
    cyc(0, 1, 32'h20, 32'h0BADF00D);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rw_new_c0 got=%b exp=1", stall); end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rw_new_c2 got=%b exp=0", stall); end
    cyc(0, 0, 0, 0);
    checks++; if (dbg !== 32'h0BADF00D) begin failures++; $display("FAIL rw_new_dbg got=%h exp=0badf00d", dbg); end
  endtask

  task automatic test_back_to_back;
    cyc(0, 1, 32'h30, 32'h5EED1234);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 32'h30, 0);
    checks++; if ({stall, dout} !== {1'b1, 32'h0}) begin failures++; $display("FAIL b2b_c3 got=%b/%h exp=1/0", stall, dout); end
    cyc(0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_c4 got=%b exp=1", stall); end
    cyc(0, 0, 0, 0);
    checks++; if ({stall, dout} !== {1'b0, 32'h5EED1234}) begin failures++; $display("FAIL b2b_c5 got=%b/%h exp=0/5eed1234", stall, dout); end
  endtask

  task automatic test_zero_wait;
    cyc(0, 1, 32'h4, 32'hA5A5A5A5);
    checks++; if ({stall0, err0, dout0} !== 34'h0) begin failures++; $display("FAIL ws0_wr got=%b%b/%h exp=00/0", stall0, err0, dout0); end
    cyc(1, 0, 32'h4, 0);
    checks++; if ({stall0, dout0} !== {1'b0, 32'hA5A5A5A5}) begin failures++; $display("FAIL ws0_rd got=%b/%h exp=0/a5a5a5a5", stall0, dout0); end
    cyc(0, 0, 0, 0);
    checks++; if ({stall0, dout0} !== {1'b0, 32'h0}) begin failures++; $display("FAIL ws0_idle got=%b/%h exp=0/0", stall0, dout0); end
    dbg_addr = 10'd1; #1;
    checks++; if (dbg0 !== 32'hA5A5A5A5) begin failures++; $display("FAIL ws0_dbg got=%h exp=a5a5a5a5", dbg0); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_errors;
    test_capture;
    test_reset_wait;
    test_back_to_back;
    test_zero_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
